// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between the
// instruction-fetch requester (I, read-only) and the load/store requester (D).
// Every access runs IDLE -> ACC -> RESP. D has priority over I, but after
// MAX_WAIT consecutive losses I is forced to win the next arbitration.
// Ports:
//   clk, reset                         clock, async active-high reset
//   i_req, i_addr / i_done, i_rdata    fetch request / completion + data
//   d_req, d_we, d_addr, d_wdata       load/store request
//   d_done, d_rdata                    load/store completion + load data
//   mem_addr, mem_we, mem_wdata        registered memory command
//   mem_rdata                          memory data, one cycle after address
// Optional (macro ARB_STATS_EN):
//   conflict_cnt  count of IDLE cycles with both requests pending
//   starve_hit    pulse when I wins only because of the starvation guard
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]   conflict_cnt,
    output logic          starve_hit
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;       // 1 = D owns the access
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;

    logic both;
    logic force_i;
    logic gnt_d;
    logic gnt_i;

    // Arbitration is only meaningful in IDLE; grants are qualified here.
    always_comb begin
        both    = i_req & d_req;
        force_i = both & (wait_cnt_q == MAX_W);
        gnt_d   = (state_q == S_IDLE) & d_req & ~force_i;
        gnt_i   = (state_q == S_IDLE) & i_req & ~gnt_d;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_d | gnt_i) state_d = S_ACC;
            S_ACC:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_we  = (state_q == S_ACC) & mem_we_q;
        i_done  = (state_q == S_RESP) & ~owner_q;
        d_done  = (state_q == S_RESP) & owner_q;
        i_rdata = i_done ? mem_rdata : '0;
        d_rdata = d_done ? mem_rdata : '0;
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Command capture and starvation counter
    always_comb begin
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        wait_cnt_d  = wait_cnt_q;
        if (gnt_d) begin
            owner_d     = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
            if (both && wait_cnt_q != MAX_W) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else if (gnt_i) begin
            owner_d    = 1'b0;
            mem_addr_d = i_addr;
            mem_we_d   = 1'b0;
            wait_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (state_q == S_IDLE && both) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 32'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
    // force_i already implies both requests, so I is the winner here.
    assign starve_hit   = gnt_i & force_i;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with a
// behavioural synchronous-read memory attached to the memory port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] conflict_cnt;
    logic        starve_hit;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:255];

    mem_port_arbiter #(.MAX_WAIT(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .starve_hit   (starve_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int first_i;
    int nd;
    int ni;
    int we_seen;
    int starve_n;
    logic [31:0] conf_base;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hDEAD_0000 | k;
        mem[8'h04] = 32'h0050_0113;
        mem[8'h08] = 32'hAAAA_0001;
        mem[8'h0C] = 32'hBBBB_0002;
        mem[8'h10] = 32'h1111_0040;
        mem[8'h11] = 32'h1111_0044;
        mem[8'h12] = 32'h1111_0048;

        // reset state
        @(negedge clk);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_wait", dut.wait_cnt_q, 0);
        cyc();
        reset = 1'b0;
        cyc();

        // single fetch
        i_req = 1'b1; i_addr = 32'h10;
        we_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (c == 0) check("f_done_c0", i_done, 0);
            if (c == 1) check("f_addr_c1", mem_addr, 32'h10);
            if (c == 1) check("f_done_c1", i_done, 0);
            if (c == 2) check("f_done_c2", i_done, 1);
            if (c == 2) check("f_rdata_c2", i_rdata, 32'h0050_0113);
            if (c == 2) check("f_d_done", d_done, 0);
            cyc();
        end
        i_req = 1'b0;
        check("f_no_we", we_seen, 0);
        cyc();

        // single store then load back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h7;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("s_we_c0", mem_we, 0);
            if (c == 1) check("s_we_c1", mem_we, 1);
            if (c == 1) check("s_addr_c1", mem_addr, 32'h64);
            if (c == 1) check("s_wdata_c1", mem_wdata, 32'h7);
            if (c == 2) check("s_we_c2", mem_we, 0);
            if (c == 2) check("s_done_c2", d_done, 1);
            if (c == 2) check("s_i_rdata", i_rdata, 0);
            if (c == 4) check("l_we_c4", mem_we, 0);
            if (c == 5) check("l_done_c5", d_done, 1);
            if (c == 5) check("l_rdata_c5", d_rdata, 32'h7);
            cyc();
            if (c == 2) d_we = 1'b0;
        end
        d_req = 1'b0;
        cyc();

        // simultaneous requests, starvation guard
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        first_i = -1; nd = 0; starve_n = 0; we_seen = 0;
        conf_base = '0;
`ifdef ARB_STATS_EN
        conf_base = conflict_cnt;
`endif
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (d_done) begin
                nd++;
                check("c_d_rdata", d_rdata, 32'hBBBB_0002);
            end
            if (i_done && first_i < 0) begin
                first_i = c;
                check("c_d_before_i", nd, 4);
                check("c_i_rdata", i_rdata, 32'hAAAA_0001);
            end
            if (c == 12) check("c_wait_max", dut.wait_cnt_q, 4);
            if (c == 13) check("c_wait_clr", dut.wait_cnt_q, 0);
            if (c == 17) check("c_d_after_i", d_done, 1);
`ifdef ARB_STATS_EN
            if (starve_hit) starve_n++;
            if (c == 12) check("c_starve_c12", starve_hit, 1);
`endif
            cyc();
            if (c == 14) i_req = 1'b0;
        end
        d_req = 1'b0;
        check("c_first_i", first_i, 14);
        check("c_d_count", nd, 5);
        check("c_no_we", we_seen, 0);
`ifdef ARB_STATS_EN
        check("c_starve_n", starve_n, 1);
        check("c_conflicts", conflict_cnt - conf_base, 5);
`endif
        cyc();

        // back-to-back fetches
        i_req = 1'b1;
        ni = 0;
        for (int c = 0; c < 10; c++) begin
            i_addr = 32'h40 + 32'(4 * (c / 3));
            @(negedge clk);
            if (i_done) ni++;
            if (c % 3 == 1)
                check("b_addr", mem_addr, 32'h40 + 32'(4 * (c / 3)));
            if (c % 3 == 2) begin
                check("b_done", i_done, 1);
                check("b_rdata", i_rdata, 32'h1111_0040 + 32'(4 * (c / 3)));
            end
            cyc();
            if (c == 8) i_req = 1'b0;
        end
        check("b_count", ni, 3);
        cyc();

        // reset during a store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55;
        @(negedge clk);
        check("r_we_c0", mem_we, 0);
        cyc();
        @(negedge clk);
        check("r_we_c1", mem_we, 1);
        #2 reset = 1'b1;
        #1;
        check("r_we_async", mem_we, 0);
        check("r_addr", mem_addr, 0);
        check("r_wdata", mem_wdata, 0);
        check("r_d_done", d_done, 0);
        @(posedge clk);
        #1;
        check("r_d_done_b", d_done, 0);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) check("r2_we_c1", mem_we, 1);
            if (c == 1) check("r2_addr_c1", mem_addr, 32'h80);
            if (c == 2) check("r2_done_c2", d_done, 1);
            if (c == 5) check("r2_ld_done", d_done, 1);
            if (c == 5) check("r2_ld_data", d_rdata, 32'h55);
            cyc();
            if (c == 2) d_we = 1'b0;
        end
        d_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters of the multicycle RISC-V core.
- Requester I is the instruction-fetch path (read-only); requester D is the load/store path.
- Sequences each access through a fixed three-state FSM: arbitrate, issue, respond.
- Fixed D-over-I priority, with a starvation guard that forces an I grant after a bounded number of losses.

Parameters:
- MAX_WAIT, 4, number of consecutive arbitration losses by I after which I wins the next arbitration (legal range 1..255).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_req  in  1  fetch request; held high with i_addr stable until i_done
- i_addr  in  AW  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid this cycle
- i_rdata  out  DW  fetch data
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  one-cycle pulse: data access complete, d_rdata valid this cycle (loads)
- d_rdata  out  DW  load data
- mem_addr  out  AW  registered memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  registered memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after the address is sampled (synchronous read)

Behaviour:
- States: IDLE -> ACC -> RESP -> IDLE; no other transitions.
- IDLE arbitration (cycle N):
  - Neither request: stay in IDLE.
  - Only one request: that requester wins.
  - Both requests: D wins unless wait_cnt == MAX_WAIT, in which case I wins.
  - On any grant: register the winner's address (and, for D, d_we and d_wdata) into mem_addr, mem_we_q and mem_wdata; record owner; go to ACC.
- ACC (N+1): mem_we = mem_we_q (owner D stores only); memory samples at the N+1 edge; go to RESP.
- RESP (N+2): owner's done = 1; owner's rdata = mem_rdata (passed through combinationally); go to IDLE.
  - Requester may drop or change its request at the end of N+2.
  - IDLE at N+3 samples fresh requests.
- Throughput: one access per 3 cycles. A store completes the same way; d_rdata is don't-care on stores.
- Non-owner done is 0. Non-owner rdata is 0 when its done is 0.
- mem_we is 0 in IDLE and RESP. mem_addr and mem_wdata hold their last value outside ACC.
- wait_cnt:
  - Width 8.
  - Increments (saturating at MAX_WAIT) on each IDLE cycle where i_req and d_req are both 1 and D wins.
  - Clears on every I grant; otherwise holds.
- Reset values: state IDLE, owner I, mem_addr 0, mem_wdata 0, mem_we 0, i_done 0, d_done 0, i_rdata 0, d_rdata 0, wait_cnt 0.
- Reset asserted mid-transaction: reset is asynchronous, so mem_we drops immediately. The in-flight access is abandoned and no done pulse is issued; requesters reissue after reset.
- A request that drops before its done pulse is a protocol violation. The granted access still completes and still pulses done.
- Addresses are passed unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output port conflict_cnt, 32 bits.
  - Counts IDLE cycles with i_req and d_req both 1; wraps modulo 2^32; reset value 0.
  - Adds output port starve_hit, 1 bit: a one-cycle pulse when I wins because wait_cnt == MAX_WAIT.
- Undefined: neither port exists and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Single fetch: i_req=1, i_addr=0x10 at cycle 0, memory word 0x00500113 -> mem_addr=0x10 at cycle 1, i_done=1 and i_rdata=0x00500113 at cycle 2, mem_we never 1.
- Single store: d_req=1, d_we=1, d_addr=0x64, d_wdata=0x7 -> mem_we=1 only at cycle 1 with mem_addr=0x64 and mem_wdata=0x7; d_done=1 at cycle 2; a subsequent load of 0x64 returns d_rdata=0x7.
- Simultaneous requests (MAX_WAIT=4), both held continuously, D reissuing after each done -> grant order D,D,D,D,I,D,...; i_done first at cycle 14; wait_cnt returns to 0 after the I grant.
- Back-to-back: i_req held with a new address presented each cycle after i_done -> grants at cycles 0, 3, 6; done at cycles 2, 5, 8; no lost or duplicated accesses.
- Reset at cycle 1 of a store -> mem_we falls immediately, no d_done pulse, all outputs at reset values; after release a reissued store completes normally.
- With ARB_STATS_EN: 10 cycles of both requests held -> conflict_cnt equals the count of IDLE cycles with both requests; starve_hit pulses exactly once per forced I grant.
